// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared widths and constants for the extended-precision datapath
//
// Purpose: single source for mantissa/exponent/count widths used by the
//          normalizer and its leading-zero counter.
// Ports:   none (package).
package fpu_pkg;

  localparam int MW = 80;  // mantissa width
  localparam int EW = 15;  // biased exponent width
  localparam int CW = 7;   // leading-zero count width, holds 0..MW

  // Count reported for an all-zero mantissa.
  localparam logic [CW-1:0] MANT_ZERO_CNT = CW'(MW);

  // Largest biased exponent (all ones).
  localparam logic [EW-1:0] EXP_MAX = '1;

endpackage

// File: rtl/lza_80.sv
// rtl/lza_80.sv - combinational 80-bit leading-zero counter
//
// Purpose: count the zeros above the most significant set bit of mant_i.
// Ports:
//   mant_i  in  MW  mantissa to scan
//   cnt_o   out CW  leading-zero count, MW when mant_i is all zero
module lza_80
  import fpu_pkg::*;
(
  input  logic [MW-1:0] mant_i,
  output logic [CW-1:0] cnt_o
);

  // Scan upward from the LSB; the last set bit seen is the most
  // significant one, so its count overwrites any earlier match.
  always_comb begin
    cnt_o = MANT_ZERO_CNT;
    for (int i = 0; i < MW; i++) begin
      if (mant_i[i]) begin
        cnt_o = CW'(MW - 1 - i);
      end
    end
  end

endmodule

// File: rtl/norm_shift_80.sv
// rtl/norm_shift_80.sv - two-stage pipelined 80-bit mantissa normalizer
//
// Purpose: stage 1 registers the operand with its leading-zero count;
//          stage 2 left-shifts the mantissa, adjusts the exponent and
//          clamps at denormal range. Valid/ready on both sides.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   upstream handshake
//   in_mant/exp/sign    operand
//   out_valid/out_ready downstream handshake
//   out_mant/exp/sign   normalized result
//   out_zero            input mantissa was zero
//   out_denorm          shift clamped by exponent, or input exponent was 0
//   out_shamt           shift actually applied
module norm_shift_80
  import fpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] in_mant,
  input  logic [EW-1:0] in_exp,
  input  logic          in_sign,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] out_mant,
  output logic [EW-1:0] out_exp,
  output logic          out_sign,
  output logic          out_zero,
  output logic          out_denorm,
  output logic [CW-1:0] out_shamt
);

  // Stage 1 registers
  logic          s1_valid_q;
  logic [MW-1:0] s1_mant_q;
  logic [EW-1:0] s1_exp_q;
  logic          s1_sign_q;
  logic [CW-1:0] s1_cnt_q;
  logic          s1_zero_q;

  // Stage 2 registers drive the outputs directly
  logic          s2_valid_q;
  logic [MW-1:0] s2_mant_q;
  logic [EW-1:0] s2_exp_q;
  logic          s2_sign_q;
  logic          s2_zero_q;
  logic          s2_denorm_q;
  logic [CW-1:0] s2_shamt_q;

  // Stage 2 next-state
  logic [MW-1:0] s2_mant_d;
  logic [EW-1:0] s2_exp_d;
  logic          s2_denorm_d;
  logic [CW-1:0] s2_shamt_d;

  logic [CW-1:0] lzc_cnt;
  logic [EW-1:0] cnt_ext;
  logic          s2_adv;
  logic          s1_load;

  lza_80 u_lza (
    .mant_i (in_mant),
    .cnt_o  (lzc_cnt)
  );

  assign s2_adv   = !s2_valid_q || out_ready;
  // Gated by rst so that every output reads 0 while reset is held.
  assign in_ready = !rst && (!s1_valid_q || s2_adv);
  assign s1_load  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mant_q  <= '0;
      s1_exp_q   <= '0;
      s1_sign_q  <= 1'b0;
      s1_cnt_q   <= '0;
      s1_zero_q  <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= 1'b1;
      s1_mant_q  <= in_mant;
      s1_exp_q   <= in_exp;
      s1_sign_q  <= in_sign;
      s1_cnt_q   <= lzc_cnt;
      s1_zero_q  <= (lzc_cnt == MANT_ZERO_CNT);
    end else if (s2_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  assign cnt_ext = EW'(s1_cnt_q);

  // Shift selection: full normalization when the exponent can absorb it,
  // otherwise shift only down to biased exponent 1 and flag denormal.
  // In the clamped case exp <= cnt <= 79, so exp-1 fits in CW bits.
  always_comb begin
    s2_shamt_d  = '0;
    s2_exp_d    = '0;
    s2_denorm_d = 1'b0;
    if (s1_zero_q) begin
      s2_shamt_d  = '0;
      s2_exp_d    = '0;
      s2_denorm_d = 1'b0;
    end else if (s1_exp_q > cnt_ext) begin
      s2_shamt_d  = s1_cnt_q;
      s2_exp_d    = s1_exp_q - cnt_ext;
      s2_denorm_d = 1'b0;
    end else if (s1_exp_q == '0) begin
      s2_shamt_d  = '0;
      s2_exp_d    = '0;
      s2_denorm_d = 1'b1;
    end else begin
      s2_shamt_d  = CW'(s1_exp_q - EW'(1));
      s2_exp_d    = '0;
      s2_denorm_d = 1'b1;
    end
    s2_mant_d = s1_mant_q << s2_shamt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      s2_mant_q   <= '0;
      s2_exp_q    <= '0;
      s2_sign_q   <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_denorm_q <= 1'b0;
      s2_shamt_q  <= '0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_mant_q   <= s2_mant_d;
        s2_exp_q    <= s2_exp_d;
        s2_sign_q   <= s1_sign_q;
        s2_zero_q   <= s1_zero_q;
        s2_denorm_q <= s2_denorm_d;
        s2_shamt_q  <= s2_shamt_d;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_mant   = s2_mant_q;
  assign out_exp    = s2_exp_q;
  assign out_sign   = s2_sign_q;
  assign out_zero   = s2_zero_q;
  assign out_denorm = s2_denorm_q;
  assign out_shamt  = s2_shamt_q;

endmodule

// File: tb/tb_norm_shift_80.sv
// tb/tb_norm_shift_80.sv - scoreboard bench for norm_shift_80
module tb_norm_shift_80;
  import fpu_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] in_mant;
  logic [EW-1:0] in_exp;
  logic          in_sign;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] out_mant;
  logic [EW-1:0] out_exp;
  logic          out_sign;
  logic          out_zero;
  logic          out_denorm;
  logic [CW-1:0] out_shamt;

  norm_shift_80 dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mant    (in_mant),
    .in_exp     (in_exp),
    .in_sign    (in_sign),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_mant   (out_mant),
    .out_exp    (out_exp),
    .out_sign   (out_sign),
    .out_zero   (out_zero),
    .out_denorm (out_denorm),
    .out_shamt  (out_shamt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [104:0] res;
    int           acc_cyc;
    bit           chk_lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   lat_mode = 0;
  bit   rand_bp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: leading zeros found by magnitude comparison against powers of two.
  function automatic logic [104:0] model(input logic [79:0] m, input logic [14:0] e, input logic s);
    int          lz;
    int          ei;
    int          sh;
    int          eo;
    logic        dn;
    logic [79:0] one;
    logic [79:0] mo;
    ei  = int'(e);
    one = 80'd1;
    if (m == 80'd0) begin
      return {80'd0, 15'd0, s, 1'b1, 1'b0, 7'd0};
    end
    lz = 0;
    while (m < (one << (79 - lz))) lz++;
    if (ei > lz) begin
      sh = lz; eo = ei - lz; dn = 1'b0;
    end else if (ei == 0) begin
      sh = 0; eo = 0; dn = 1'b1;
    end else begin
      sh = ei - 1; eo = 0; dn = 1'b1;
    end
    mo = m << sh;
    return {mo, 15'(eo), s, 1'b0, dn, 7'(sh)};
  endfunction

  task automatic send(input logic [79:0] m, input logic [14:0] e, input logic s, output int waits);
    exp_t r;
    in_mant  = m;
    in_exp   = e;
    in_sign  = s;
    in_valid = 1'b1;
    waits    = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        r.res     = model(m, e, s);
        r.acc_cyc = cyc;
        r.chk_lat = lat_mode;
        sb.push_back(r);
        @(posedge clk);
        #1;
        break;
      end
      waits++;
      if (waits > 200) begin
        check("accept_timeout", 128'(waits), 128'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain_empty", 128'(sb.size()), 128'd0);
  endtask

  // Monitor: pops on every output transfer and checks stall stability.
  initial begin
    logic [104:0] snap;
    logic [104:0] cur;
    bit           held;
    exp_t         r;
    held = 0;
    forever begin
      @(negedge clk);
      cur = {out_mant, out_exp, out_sign, out_zero, out_denorm, out_shamt};
      if (rst) begin
        held = 0;
      end else begin
        if (held && out_valid) check("stall_stable", 128'(cur), 128'(snap));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_output", 128'(cur), 128'd0);
          end else begin
            r = sb.pop_front();
            check("result", 128'(cur), 128'(r.res));
            if (r.chk_lat) check("latency", 128'(cyc - r.acc_cyc), 128'd2);
          end
        end
        held = out_valid && !out_ready;
        snap = cur;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    end
  end

  function automatic logic [79:0] rand_mant();
    logic [95:0] w;
    w = {$urandom, $urandom, $urandom};
    return w[79:0] >> $urandom_range(0, 80);
  endfunction

  function automatic logic [14:0] rand_exp();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 1) == 1) return 15'($urandom_range(0, 90));
    return w[14:0];
  endfunction

  initial begin
    int w0, w1, w2, wt;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mant   = '0;
    in_exp    = '0;
    in_sign   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          128'({in_ready, out_valid, out_mant, out_exp, out_sign, out_zero, out_denorm, out_shamt}),
          128'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases including exponent/count boundaries.
    lat_mode = 1;
    send(80'h0000_8000_0000_0000_0000, 15'd100, 1'b1, wt);
    send(80'd0, 15'd500, 1'b0, wt);
    send(80'd1, 15'd10, 1'b0, wt);
    send(80'h1234, 15'd0, 1'b1, wt);
    send(80'd1, 15'd79, 1'b0, wt);
    send(80'd1, 15'd80, 1'b1, wt);
    send(80'h8000_0000_0000_0000_0000, 15'd0, 1'b0, wt);
    send(80'h8000_0000_0000_0000_0000, EXP_MAX, 1'b1, wt);
    drain();

    // Back-to-back throughput: in_ready never drops.
    for (int i = 0; i < 8; i++) begin
      send(rand_mant(), rand_exp(), 1'($urandom_range(0, 1)), wt);
      check("b2b_no_wait", 128'(wt), 128'd0);
    end
    drain();
    lat_mode = 0;

    // Backpressure: out_ready low for 5 cycles while 3 operands arrive.
    out_ready = 1'b0;
    fork
      begin
        send(rand_mant(), rand_exp(), 1'b0, w0);
        send(rand_mant(), rand_exp(), 1'b1, w1);
        send(rand_mant(), rand_exp(), 1'b0, w2);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    check("bp_first_wait", 128'(w0), 128'd0);
    check("bp_second_wait", 128'(w1), 128'd0);
    check("bp_third_blocked", 128'(w2 > 0), 128'd1);
    drain();

    // Random traffic with random backpressure and idle gaps.
    rand_bp = 1;
    for (int i = 0; i < 60; i++) begin
      send(rand_mant(), rand_exp(), 1'($urandom_range(0, 1)), wt);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rand_bp = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    send(rand_mant(), rand_exp(), 1'b1, wt);
    send(rand_mant(), rand_exp(), 1'b1, wt);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs",
          128'({in_ready, out_valid, out_mant, out_exp, out_sign, out_zero, out_denorm, out_shamt}),
          128'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    lat_mode  = 1;
    send(80'h0000_0000_00F0_0000_0000, 15'd200, 1'b1, wt);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
